// File: rtl/customized_float_to_fixed_pkg.sv
// Shared constants and encodings for the float-to-fixed converter blocks.
package customized_float_to_fixed_pkg;

    localparam int EXP_W    = 8;
    localparam int EXP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Which result the CALC phase produces when its counter runs out.
    typedef enum logic [1:0] {
        PATH_NORMAL = 2'd0,
        PATH_ZERO   = 2'd1,
        PATH_SAT    = 2'd2
    } path_t;

endpackage

// File: rtl/fixed_shift_step.sv
// One-bit logical shifter applied to the working magnitude once per CALC cycle.
module fixed_shift_step #(
    parameter int width = 48
) (
    input  logic [width-1:0] w_in,
    input  logic             shift_left,
    output logic [width-1:0] w_out
);

    assign w_out = shift_left ? {w_in[width-2:0], 1'b0} : {1'b0, w_in[width-1:1]};

endmodule

// File: rtl/customized_float_to_fixed.sv
// Converts a custom-width IEEE-style float to sign/magnitude fixed point by
// sliding the significand one bit per cycle until its binary point lines up.
module customized_float_to_fixed
    import customized_float_to_fixed_pkg::*;
#(
    parameter int montissa_len = 23,
    parameter int int_len      = 32,
    parameter int fra_len      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [montissa_len+EXP_W:0]     ieee_val,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [int_len-1:0]              o_integer,
    output logic [fra_len-1:0]              o_fraction,
    output logic                            sign_flag,
    output logic                            overflow,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int W_LEN = int_len + fra_len;
    localparam int CNT_W = $clog2(W_LEN + 1);

    state_t             state;
    path_t              path;
    logic [W_LEN-1:0]   w;
    logic [W_LEN-1:0]   w_next;
    logic [CNT_W-1:0]   cnt;
    logic               shift_left;
    logic               sign_r;

    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [montissa_len-1:0] in_man;

    assign in_sign = ieee_val[montissa_len+EXP_W];
    assign in_exp  = ieee_val[montissa_len +: EXP_W];
    assign in_man  = ieee_val[montissa_len-1:0];

    int               e_i;
    int               k_i;
    path_t            acc_path;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_left;

    // k is how far the significand's LSB sits from the output's 2^-fra_len position.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        e_i      = int'(in_exp) - EXP_BIAS;
        k_i      = e_i - montissa_len + fra_len;
        acc_path = PATH_NORMAL;
        acc_cnt  = '0;
        acc_left = 1'b0;
        if (in_exp == '0 || k_i <= -(montissa_len + 1)) begin
            acc_path = PATH_ZERO;
        end else if (in_exp == '1 || e_i >= int_len) begin
            acc_path = PATH_SAT;
        end else begin
            acc_left = (k_i > 0);
            acc_cnt  = CNT_W'((k_i < 0) ? -k_i : k_i);
        end
    end

    fixed_shift_step #(
        .width (W_LEN)
    ) u_shift (
        .w_in       (w),
        .shift_left (shift_left),
        .w_out      (w_next)
    );

    // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            path       <= PATH_NORMAL;
            w          <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            sign_r     <= 1'b0;
            o_integer  <= '0;
            o_fraction <= '0;
            sign_flag  <= 1'b0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r     <= in_sign;
                        w          <= W_LEN'({1'b1, in_man});
                        cnt        <= acc_cnt;
                        shift_left <= acc_left;
                        path       <= acc_path;
                        in_ready   <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        w   <= w_next;
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Shortcuts also finish here, so every path pays the final CALC cycle.
                        case (path)
                            PATH_ZERO: begin
                                o_integer  <= '0;
                                o_fraction <= '0;
                                sign_flag  <= 1'b0;
                                overflow   <= 1'b0;
                            end
                            PATH_SAT: begin
                                o_integer  <= '1;
                                o_fraction <= '1;
                                sign_flag  <= sign_r;
                                overflow   <= 1'b1;
                            end
                            default: begin
                                o_integer  <= w[W_LEN-1:fra_len];
                                o_fraction <= w[fra_len-1:0];
                                sign_flag  <= sign_r;
                                overflow   <= 1'b0;
                            end
                        endcase
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_customized_float_to_fixed.sv
// Directed-vector bench for customized_float_to_fixed at 23/32/16.
module tb_customized_float_to_fixed;

    logic        clk;
    logic        rst;
    logic [31:0] ieee_val;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] o_integer;
    logic [15:0] o_fraction;
    logic        sign_flag;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    customized_float_to_fixed #(
        .montissa_len (23),
        .int_len      (32),
        .fra_len      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ieee_val   (ieee_val),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .o_integer  (o_integer),
        .o_fraction (o_fraction),
        .sign_flag  (sign_flag),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Entered and left #1 after a rising edge.
    task automatic send(input string tag, input logic [31:0] val);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
        ieee_val = val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
    endtask

    task automatic check_out(input string tag, input logic [31:0] ei, input logic [15:0] ef,
                             input logic s, input logic ov);
        check({tag, "_int"},  64'(o_integer),  64'(ei));
        check({tag, "_frac"}, 64'(o_fraction), 64'(ef));
        check({tag, "_sign"}, 64'(sign_flag),  64'(s));
        check({tag, "_ovf"},  64'(overflow),   64'(ov));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] val, input int lat,
                       input logic [31:0] ei, input logic [15:0] ef, input logic s, input logic ov);
        send(tag, val);
        wait_valid(tag, lat);
        check_out(tag, ei, ef, s, ov);
        handshake(tag);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ieee_val  = '0;
        out_ready = 1'b1;
        #12;
        check_out("reset", 32'h0, 16'h0, 1'b0, 1'b0);
        check("reset_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", 64'(in_ready), 64'd1);

        run("p1_5",    32'h3FC00000,  8, 32'h00000001, 16'h8000, 1'b0, 1'b0);
        run("m2_25",   32'hC0100000,  7, 32'h00000002, 16'h4000, 1'b1, 1'b0);
        run("p2_31",   32'h4F000000, 25, 32'h80000000, 16'h0000, 1'b0, 1'b0);
        run("p2_32",   32'h4F800000,  1, 32'hFFFFFFFF, 16'hFFFF, 1'b0, 1'b1);
        run("ninf",    32'hFF800000,  1, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 1'b1);
        run("p2_m16",  32'h37800000, 24, 32'h00000000, 16'h0001, 1'b0, 1'b0);
        run("p2_m17",  32'h37000000,  1, 32'h00000000, 16'h0000, 1'b0, 1'b0);
        run("m2_m17",  32'hB7000000,  1, 32'h00000000, 16'h0000, 1'b0, 1'b0);
        run("zero",    32'h00000000,  1, 32'h00000000, 16'h0000, 1'b0, 1'b0);
        run("pi",      32'h40490FDB,  7, 32'h00000003, 16'h243F, 1'b0, 1'b0);

        // Consumer stall: result must hold, and input pulses must be dropped.
        send("stall", 32'h3FC00000);
        out_ready = 1'b0;
        wait_valid("stall", 8);
        check_out("stall", 32'h1, 16'h8000, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ieee_val = 32'h4F800000;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            if (o_integer !== 32'h1 || o_fraction !== 16'h8000 || overflow !== 1'b0 ||
                sign_flag !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("stall_hold", 64'(bad), 64'd0);
        handshake("stall");
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("stall_no_queue", 64'(bad), 64'd0);

        // Reset in the middle of a long left-shift conversion.
        send("rst", 32'h4F000000);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_out("rst_mid", 32'h0, 16'h0, 1'b0, 1'b0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("rst_no_output", 64'(bad), 64'd0);
        run("post_rst", 32'h3FC00000, 8, 32'h00000001, 16'h8000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
